muxn_control_pipe: RTL

Parametrised N-channel, WIDTH-bit gated multiplexer control stage with registered output and valid/ready flow control. It generalises the single-bit 2:1 gated control mux to many channels. It adds fixed-select and round-robin modes and a two-entry output buffer, so upstream producers and downstream consumers in the adiabatic MIPS25 datapath can stall independently. It sits between operand sources and a shared downstream stage, such as a register-file write port or a shared bus.

---
 rtl/mips25_mux_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/muxn_control_pipe.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips25_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips25_mux_pkg
// Description : Shared types and helpers for the N-channel control mux stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips25_mux_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   localparam int BUF_DEPTH = 2;

   // Channel index increment with wrap back to 0 after n-1.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return ((idx + 1) >= n) ? 0 : (idx + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant search starting at a pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import mips25_mux_pkg::*;
#(
   parameter  int NCH  = 4,
   localparam int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req_i,
   input  logic [SELW-1:0] ptr_i,
   input  logic            advance_i,
   output logic [SELW-1:0] grant_o,
   output logic            grant_valid_o,
   output logic [SELW-1:0] ptr_next_o
);

   int idx;

   // Walk from farthest to nearest so the closest requester at/after ptr wins.
   always_comb begin
      grant_o       = '0;
      grant_valid_o = 1'b0;
      idx           = 0;
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = (int'(ptr_i) + k) % NCH;
         if (req_i[idx]) begin
            grant_o       = SELW'(idx);
            grant_valid_o = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_next_o = ptr_i;
      if (advance_i && grant_valid_o) begin
         ptr_next_o = SELW'(wrap_inc(32'(grant_o), NCH));
      end
   end

endmodule
`default_nettype wire

// File: rtl/muxn_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : muxn_control_pipe
// Description : N-channel gated control mux with fixed/round-robin select and
//               a two-entry registered output buffer (valid/ready both sides).
//               Optional per-beat parity output: MUXN_CONTROL_PIPE_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module muxn_control_pipe
   import mips25_mux_pkg::*;
#(
   parameter  int NCH   = 4,
   parameter  int WIDTH = 32,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                 clkpos,
   input  logic                 rst,
   input  logic                 gate,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
   output logic                 out_par,
`endif
   input  logic                 out_ready
);

   localparam logic [1:0] S_EMPTY = EMPTY;
   localparam logic [1:0] S_ONE   = ONE;
   localparam logic [1:0] S_FULL  = FULL;

   logic [1:0]       state_q, state_d;
   logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] data_q [BUF_DEPTH];
   logic [WIDTH-1:0] data_d [BUF_DEPTH];
   logic [SELW-1:0]  chan_q [BUF_DEPTH];
   logic [SELW-1:0]  chan_d [BUF_DEPTH];
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
   logic             par_q  [BUF_DEPTH];
   logic             par_d  [BUF_DEPTH];
`endif

   logic [2**SELW-1:0] valid_ext;
   logic               is_rr;
   logic               fix_grant_valid;
   logic [SELW-1:0]    rr_grant;
   logic               rr_grant_valid;
   logic [SELW-1:0]    rr_ptr_next;
   logic [SELW-1:0]    grant;
   logic               grant_valid;
   logic               push;
   logic               pop;
   logic [WIDTH-1:0]   new_data;

   assign is_rr     = (mode == MODE_RR);
   assign valid_ext = (2**SELW)'(in_valid);

   // Out-of-range selects (possible when NCH is not a power of two) never grant.
   assign fix_grant_valid = ({1'b0, sel} < (SELW+1)'(NCH)) && valid_ext[sel];

   rr_arbiter #(
      .NCH (NCH)
   ) u_rr_arbiter (
      .req_i         (in_valid),
      .ptr_i         (rr_ptr_q),
      .advance_i     (push && is_rr),
      .grant_o       (rr_grant),
      .grant_valid_o (rr_grant_valid),
      .ptr_next_o    (rr_ptr_next)
   );

   assign grant       = is_rr ? rr_grant : sel;
   assign grant_valid = is_rr ? rr_grant_valid : fix_grant_valid;

   // Ready never looks at out_ready, so there is no out_ready->in_ready path.
   assign push = !rst && gate && (state_q != S_FULL) && grant_valid;
   assign pop  = out_valid_q && out_ready;

   always_comb begin
      in_ready = '0;
      if (push) begin
         in_ready[grant] = 1'b1;
      end
   end

   assign new_data = in_data[int'(grant)*WIDTH +: WIDTH];

   // Fixed-mode pushes also move the pointer so RR resumes after the last winner.
   always_comb begin
      rr_ptr_d = rr_ptr_next;
      if (push && !is_rr) begin
         rr_ptr_d = SELW'(wrap_inc(32'(sel), NCH));
      end
   end

   // Entry 0 is the head and drives the outputs directly; entry 1 is the tail.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      data_d      = data_q;
      chan_d      = chan_q;
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
      par_d       = par_q;
`endif
      case (state_q)
         S_EMPTY: begin
            if (push) begin
               data_d[0]   = new_data;
               chan_d[0]   = grant;
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
               par_d[0]    = ^new_data;
`endif
               state_d     = S_ONE;
               out_valid_d = 1'b1;
            end
         end
         S_ONE: begin
            if (push && pop) begin
               data_d[0] = new_data;
               chan_d[0] = grant;
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
               par_d[0]  = ^new_data;
`endif
            end else if (push) begin
               data_d[1] = new_data;
               chan_d[1] = grant;
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
               par_d[1]  = ^new_data;
`endif
               state_d   = S_FULL;
            end else if (pop) begin
               data_d[0]   = '0;
               chan_d[0]   = '0;
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
               par_d[0]    = 1'b0;
`endif
               state_d     = S_EMPTY;
               out_valid_d = 1'b0;
            end
         end
         S_FULL: begin
            if (pop) begin
               data_d[0] = data_q[1];
               chan_d[0] = chan_q[1];
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
               par_d[0]  = par_q[1];
`endif
               state_d   = S_ONE;
            end
         end
         default: begin
            data_d[0]   = '0;
            chan_d[0]   = '0;
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
            par_d[0]    = 1'b0;
`endif
            state_d     = S_EMPTY;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clkpos) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            data_q[i] <= '0;
            chan_q[i] <= '0;
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
            par_q[i]  <= 1'b0;
`endif
         end
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            data_q[i] <= data_d[i];
            chan_q[i] <= chan_d[i];
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
            par_q[i]  <= par_d[i];
`endif
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = data_q[0];
   assign out_chan  = chan_q[0];
`ifdef MUXN_CONTROL_PIPE_PARITY_EN
   assign out_par   = par_q[0];
`endif

endmodule
`default_nettype wire
